mux_scan_decoder: RTL and testbench

- Receive-side counterpart of the four-digit multiplexed 7-segment scan driver (mm:ss timer).
- Samples the time-multiplexed digit, anode and decimal-point bus, and rebuilds a complete mm:ss frame in BCD and in binary seconds.
- Flags malformed scans: illegal anode pattern, out-of-order digit, BCD out of range, misplaced dp.
- Used on-board as a self-check / debug tap, and as the data source for later readout logic.

---
 rtl/mux_scan_decoder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mux_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_decoder.sv
// -----------------------------------------------------------------------------
// mux_scan_decoder
//
// Receive-side tap for a four-digit multiplexed 7-segment mm:ss scan bus.
// Samples the digit / anode / decimal-point bus, waits for each anode pattern
// to dwell for STABLE_CYCLES cycles, then captures that digit into a shadow
// frame. Once idx0..idx3 have arrived in order, the frame is range checked.
// A good frame is published as BCD and as binary seconds.
// Malformed scans raise one-cycle error pulses and sticky status bits.
//
// Optional feature: define MUX_SCAN_DELTA_CHECK_EN to add tick_err and
// err_status[4]. Every committed frame after the first must then show the same
// time as the previous frame, or exactly one second later (mod 3600).
//
// Ports:
//   MUX_CLK      system clock
//   MUX_RST      asynchronous reset, active-high
//   in_digit     BCD digit on the scan bus
//   in_an        active-low one-hot anode select (1111 = blank)
//   in_dp        active-low decimal point (low only on the minutes-unit digit)
//   err_clr      synchronous clear of err_status
//   sec_unit, sec_ten, min_unit, min_ten   last committed frame, BCD
//   total_sec    last committed frame in seconds, 0..3599
//   frame_valid  one-cycle pulse on frame commit
//   an_err, seq_err, range_err, dp_err     one-cycle error pulses
//   tick_err     one-cycle time-delta error pulse (MUX_SCAN_DELTA_CHECK_EN only)
//   err_status   sticky {[tick,] dp, range, seq, an} error bits
// -----------------------------------------------------------------------------
module mux_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 2   // legal range 1..15
) (
  input  logic        MUX_CLK,
  input  logic        MUX_RST,
  input  logic [3:0]  in_digit,
  input  logic [3:0]  in_an,
  input  logic        in_dp,
  input  logic        err_clr,
  output logic [3:0]  sec_unit,
  output logic [3:0]  sec_ten,
  output logic [3:0]  min_unit,
  output logic [3:0]  min_ten,
  output logic [11:0] total_sec,
  output logic        frame_valid,
  output logic        an_err,
  output logic        seq_err,
  output logic        range_err,
  output logic        dp_err,
`ifdef MUX_SCAN_DELTA_CHECK_EN
  output logic        tick_err,
  output logic [4:0]  err_status
`else
  output logic [3:0]  err_status
`endif
);

`ifdef MUX_SCAN_DELTA_CHECK_EN
  localparam int ERR_W = 5;
`else
  localparam int ERR_W = 4;
`endif

  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {HUNT, EXP1, EXP2, EXP3, COMMIT} state_t;

  // ---------------------------------------------------------------------------
  // Input stage and dwell counter
  // ---------------------------------------------------------------------------
  logic [3:0] an_q, an_prev_q, dig_q, cnt_q;
  logic       dp_q;
  logic       strobe;

  // NOTE: clocked state is written only with non-blocking assignments. Every
  // register then updates from the values that held before the edge, whatever
  // order the statements appear in.
  always_ff @(posedge MUX_CLK or posedge MUX_RST) begin
    if (MUX_RST) begin
      // The anode registers reset to "blank". The first dwell after reset then
      // cannot be mistaken for an illegal 0000 pattern.
      an_q      <= 4'b1111;
      an_prev_q <= 4'b1111;
      dig_q     <= 4'd0;
      dp_q      <= 1'b1;
      cnt_q     <= 4'd0;
    end else begin
      an_q      <= in_an;
      dig_q     <= in_digit;
      dp_q      <= in_dp;
      an_prev_q <= an_q;
      if (an_q != an_prev_q)  cnt_q <= 4'd0;
      else if (cnt_q != STABLE) cnt_q <= cnt_q + 4'd1;
    end
  end

  // Fires in the cycle where the counter steps from STABLE-1 to STABLE. The
  // counter saturates at STABLE, so the strobe fires once per dwell.
  assign strobe = (an_q == an_prev_q) && (cnt_q == STABLE_M1);

  // ---------------------------------------------------------------------------
  // Anode decode, expected index, dp rule, range check, seconds arithmetic
  // ---------------------------------------------------------------------------
  logic [3:0]  shadow_q [4];
  state_t      state_q, state_after_cap;
  logic [1:0]  an_idx, exp_idx;
  logic        an_blank, an_illegal, dp_bad, range_ok;
  logic [11:0] su, st, mu, mt, total_calc;

  // NOTE: every variable gets a default at the top of the combinational block.
  // Any path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    an_idx     = 2'd0;
    an_blank   = 1'b0;
    an_illegal = 1'b0;
    unique case (an_q)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      4'b1111: an_blank = 1'b1;
      default: an_illegal = 1'b1;
    endcase

    exp_idx         = 2'd0;
    state_after_cap = EXP1;
    case (state_q)
      HUNT:    begin exp_idx = 2'd0; state_after_cap = EXP1;   end
      EXP1:    begin exp_idx = 2'd1; state_after_cap = EXP2;   end
      EXP2:    begin exp_idx = 2'd2; state_after_cap = EXP3;   end
      EXP3:    begin exp_idx = 2'd3; state_after_cap = COMMIT; end
      default: begin exp_idx = 2'd0; state_after_cap = HUNT;   end
    endcase

    // The decimal point is lit (low) only on the minutes-unit digit.
    dp_bad = (an_idx == 2'd2) ? dp_q : ~dp_q;

    range_ok = (shadow_q[0] <= 4'd9) && (shadow_q[1] <= 4'd5) &&
               (shadow_q[2] <= 4'd9) && (shadow_q[3] <= 4'd5);

    // Shift-add: 600 = 512+64+16+8, 60 = 32+16+8+4, 10 = 8+2.
    su = {8'd0, shadow_q[0]};
    st = {8'd0, shadow_q[1]};
    mu = {8'd0, shadow_q[2]};
    mt = {8'd0, shadow_q[3]};
    total_calc = (mt << 9) + (mt << 6) + (mt << 4) + (mt << 3)
               + (mu << 5) + (mu << 4) + (mu << 3) + (mu << 2)
               + (st << 3) + (st << 1) + su;
  end

  // ---------------------------------------------------------------------------
  // Frame state machine with registered outputs
  // ---------------------------------------------------------------------------
  logic [3:0]       sec_unit_q, sec_ten_q, min_unit_q, min_ten_q;
  logic [11:0]      total_sec_q;
  logic             frame_valid_q, an_err_q, seq_err_q, range_err_q, dp_err_q;
  logic [ERR_W-1:0] err_status_q, err_set;
`ifdef MUX_SCAN_DELTA_CHECK_EN
  logic             tick_err_q, have_prev_q;
  logic [11:0]      next_sec;
  assign next_sec = (total_sec_q == 12'd3599) ? 12'd0 : total_sec_q + 12'd1;
  assign err_set  = {tick_err_q, dp_err_q, range_err_q, seq_err_q, an_err_q};
`else
  assign err_set  = {dp_err_q, range_err_q, seq_err_q, an_err_q};
`endif

  always_ff @(posedge MUX_CLK or posedge MUX_RST) begin
    if (MUX_RST) begin
      state_q       <= HUNT;
      // NOTE: the shadow frame is only four nibbles and its reset value is
      // observable behaviour, so the array is reset. Large storage arrays are
      // normally left unreset.
      for (int i = 0; i < 4; i++) shadow_q[i] <= 4'd0;
      sec_unit_q    <= 4'd0;
      sec_ten_q     <= 4'd0;
      min_unit_q    <= 4'd0;
      min_ten_q     <= 4'd0;
      total_sec_q   <= 12'd0;
      frame_valid_q <= 1'b0;
      an_err_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      range_err_q   <= 1'b0;
      dp_err_q      <= 1'b0;
      err_status_q  <= '0;
`ifdef MUX_SCAN_DELTA_CHECK_EN
      tick_err_q    <= 1'b0;
      have_prev_q   <= 1'b0;
`endif
    end else begin
      frame_valid_q <= 1'b0;
      an_err_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      range_err_q   <= 1'b0;
      dp_err_q      <= 1'b0;
`ifdef MUX_SCAN_DELTA_CHECK_EN
      tick_err_q    <= 1'b0;
`endif
      // Sticky bits follow the pulse registers. A pulse that coincides with
      // err_clr is ORed in after the clear, so the set wins.
      err_status_q <= (err_clr ? '0 : err_status_q) | err_set;

      case (state_q)
        COMMIT: begin
          state_q <= HUNT;
          if (range_ok) begin
            sec_unit_q    <= shadow_q[0];
            sec_ten_q     <= shadow_q[1];
            min_unit_q    <= shadow_q[2];
            min_ten_q     <= shadow_q[3];
            total_sec_q   <= total_calc;
            frame_valid_q <= 1'b1;
`ifdef MUX_SCAN_DELTA_CHECK_EN
            if (have_prev_q && (total_calc != total_sec_q) &&
                (total_calc != next_sec))
              tick_err_q <= 1'b1;
            have_prev_q <= 1'b1;
`endif
          end else begin
            range_err_q <= 1'b1;
          end
        end
        default: begin
          if (strobe) begin
            if (an_illegal) begin
              an_err_q <= 1'b1;
              state_q  <= HUNT;
            end else if (!an_blank) begin
              if (an_idx == exp_idx) begin
                shadow_q[an_idx] <= dig_q;
                dp_err_q         <= dp_bad;
                state_q          <= state_after_cap;
              end else if (state_q != HUNT) begin
                // Out of order. An idx0 restarts the frame, anything else resyncs.
                seq_err_q <= 1'b1;
                if (an_idx == 2'd0) begin
                  shadow_q[0] <= dig_q;
                  dp_err_q    <= dp_bad;
                  state_q     <= EXP1;
                end else begin
                  state_q <= HUNT;
                end
              end
              // In HUNT, a non-zero index is ignored while waiting to sync.
            end
          end
        end
      endcase
    end
  end

  assign sec_unit    = sec_unit_q;
  assign sec_ten     = sec_ten_q;
  assign min_unit    = min_unit_q;
  assign min_ten     = min_ten_q;
  assign total_sec   = total_sec_q;
  assign frame_valid = frame_valid_q;
  assign an_err      = an_err_q;
  assign seq_err     = seq_err_q;
  assign range_err   = range_err_q;
  assign dp_err      = dp_err_q;
  assign err_status  = err_status_q;
`ifdef MUX_SCAN_DELTA_CHECK_EN
  assign tick_err    = tick_err_q;
`endif

endmodule

// File: tb/tb_mux_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_decoder
//
// Directed testbench for mux_scan_decoder. It drives whole mm:ss scans and
// malformed scans, then compares outputs and pulse counts with hand-computed
// values. Inputs change just after the falling edge, and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_mux_scan_decoder;

  localparam int S  = 2;   // STABLE_CYCLES
  localparam int DW = 8;   // dwell per digit
`ifdef MUX_SCAN_DELTA_CHECK_EN
  localparam int ERR_W = 5;
`else
  localparam int ERR_W = 4;
`endif

  logic             MUX_CLK = 1'b0;
  logic             MUX_RST;
  logic [3:0]       in_digit, in_an;
  logic             in_dp, err_clr;
  logic [3:0]       sec_unit, sec_ten, min_unit, min_ten;
  logic [11:0]      total_sec;
  logic             frame_valid, an_err, seq_err, range_err, dp_err;
  logic [ERR_W-1:0] err_status;
`ifdef MUX_SCAN_DELTA_CHECK_EN
  logic             tick_err;
`endif

  always #5 MUX_CLK = ~MUX_CLK;

  mux_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .MUX_CLK    (MUX_CLK),
    .MUX_RST    (MUX_RST),
    .in_digit   (in_digit),
    .in_an      (in_an),
    .in_dp      (in_dp),
    .err_clr    (err_clr),
    .sec_unit   (sec_unit),
    .sec_ten    (sec_ten),
    .min_unit   (min_unit),
    .min_ten    (min_ten),
    .total_sec  (total_sec),
    .frame_valid(frame_valid),
    .an_err     (an_err),
    .seq_err    (seq_err),
    .range_err  (range_err),
    .dp_err     (dp_err),
`ifdef MUX_SCAN_DELTA_CHECK_EN
    .tick_err   (tick_err),
`endif
    .err_status (err_status)
  );

  // Running pulse counters. Scenarios compare deltas against snapshots.
  int n_fv = 0, n_an = 0, n_seq = 0, n_rng = 0, n_dp = 0, n_tick = 0;
  always @(negedge MUX_CLK) begin
    if (frame_valid) n_fv++;
    if (an_err)      n_an++;
    if (seq_err)     n_seq++;
    if (range_err)   n_rng++;
    if (dp_err)      n_dp++;
`ifdef MUX_SCAN_DELTA_CHECK_EN
    if (tick_err)    n_tick++;
`endif
  end

  int b_fv, b_an, b_seq, b_rng, b_dp, b_tick;
  int n_vec  = 0;
  int n_miss = 0;
  int fv_at, lat_fv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_fv = n_fv; b_an = n_an; b_seq = n_seq; b_rng = n_rng; b_dp = n_dp; b_tick = n_tick;
  endtask

  // Holds one anode/digit/dp for 'cycles' falling edges. Records the first
  // edge index (1-based) that shows frame_valid high.
  task automatic send_digit(input logic [3:0] an, input logic [3:0] dig,
                            input logic dp, input int cycles);
    in_an = an; in_digit = dig; in_dp = dp;
    fv_at = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge MUX_CLK);
      if (frame_valid && fv_at == 0) fv_at = i;
    end
  endtask

  task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    send_digit(4'b1110, d0, 1'b1, DW);
    send_digit(4'b1101, d1, 1'b1, DW);
    send_digit(4'b1011, d2, 1'b0, DW);
    send_digit(4'b0111, d3, 1'b1, DW);
    lat_fv = fv_at;
    send_digit(4'b1111, 4'd0, 1'b1, 4);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge MUX_CLK);
    err_clr = 1'b0;
    @(negedge MUX_CLK);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_total"},  32'(total_sec),  32'd0);
    check({tag, "_su"},     32'(sec_unit),   32'd0);
    check({tag, "_mt"},     32'(min_ten),    32'd0);
    check({tag, "_fv"},     32'(frame_valid), 32'd0);
    check({tag, "_status"}, 32'(err_status), 32'd0);
  endtask

  initial begin
    MUX_RST = 1'b1; in_an = 4'b1111; in_digit = 4'd0; in_dp = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge MUX_CLK);
    check_zero("reset");
    MUX_RST = 1'b0;
    send_digit(4'b1111, 4'd0, 1'b1, 4);

    // Legal frame 12:43 -> 763 s. frame_valid lands S+2 edges after in_an=0111
    // is first sampled, which is the (S+3)th falling edge of that dwell.
    snap();
    send_frame(4'd3, 4'd4, 4'd2, 4'd1);
    check("f1_fv",      32'(n_fv - b_fv), 32'd1);
    check("f1_latency", 32'(lat_fv),      32'(S + 3));
    check("f1_su",      32'(sec_unit),    32'd3);
    check("f1_st",      32'(sec_ten),     32'd4);
    check("f1_mu",      32'(min_unit),    32'd2);
    check("f1_mt",      32'(min_ten),     32'd1);
    check("f1_total",   32'(total_sec),   32'd763);
    check("f1_errs",    32'((n_an - b_an) + (n_seq - b_seq) + (n_rng - b_rng) + (n_dp - b_dp)), 32'd0);
    check("f1_status",  32'(err_status[3:0]), 32'd0);

    // 59:59 -> 3599, then wrap to 00:00, then a jump to 00:05.
    send_frame(4'd9, 4'd5, 4'd9, 4'd5);
    check("f2_total", 32'(total_sec), 32'd3599);
    pulse_clr();
    snap();
    send_frame(4'd0, 4'd0, 4'd0, 4'd0);
    check("f3_total", 32'(total_sec), 32'd0);
`ifdef MUX_SCAN_DELTA_CHECK_EN
    check("f3_tick_wrap", 32'(n_tick - b_tick), 32'd0);
`endif
    snap();
    send_frame(4'd5, 4'd0, 4'd0, 4'd0);
    check("f4_total", 32'(total_sec), 32'd5);
`ifdef MUX_SCAN_DELTA_CHECK_EN
    check("f4_tick",    32'(n_tick - b_tick), 32'd1);
    check("f4_status4", 32'(err_status[4]),   32'd1);
`endif

    // Illegal anode 1001 mid-scan, then idx2/idx3 only: no frame.
    pulse_clr();
    snap();
    send_digit(4'b1110, 4'd1, 1'b1, DW);
    send_digit(4'b1101, 4'd2, 1'b1, DW);
    send_digit(4'b1001, 4'd0, 1'b1, 4);
    send_digit(4'b1011, 4'd3, 1'b0, DW);
    send_digit(4'b0111, 4'd0, 1'b1, DW);
    send_digit(4'b1111, 4'd0, 1'b1, 4);
    check("an_pulse",  32'(n_an - b_an),      32'd1);
    check("an_fv",     32'(n_fv - b_fv),      32'd0);
    check("an_seq",    32'(n_seq - b_seq),    32'd0);
    check("an_status", 32'(err_status[3:0]),  32'd1);
    check("an_hold",   32'(total_sec),        32'd5);
    send_frame(4'd1, 4'd2, 4'd3, 4'd0);
    check("an_refv",   32'(n_fv - b_fv),      32'd1);
    check("an_retot",  32'(total_sec),        32'd201);
    pulse_clr();
    check("clr_status", 32'(err_status[3:0]), 32'd0);

    // idx0 then idx2: sequence error, then a clean 00:00 frame.
    snap();
    send_digit(4'b1110, 4'd4, 1'b1, DW);
    send_digit(4'b1011, 4'd4, 1'b0, DW);
    send_digit(4'b1111, 4'd0, 1'b1, 4);
    check("seq_pulse", 32'(n_seq - b_seq), 32'd1);
    check("seq_nofv",  32'(n_fv - b_fv),   32'd0);
    send_frame(4'd0, 4'd0, 4'd0, 4'd0);
    check("seq_fv",     32'(n_fv - b_fv),     32'd1);
    check("seq_total",  32'(total_sec),       32'd0);
    check("seq_status", 32'(err_status[3:0]), 32'd2);
    check("seq_dp",     32'(n_dp - b_dp),     32'd0);

    // Seconds-ten of 7 fails the range check, and the outputs hold.
    pulse_clr();
    snap();
    send_frame(4'd1, 4'd7, 4'd0, 4'd0);
    check("rng_pulse", 32'(n_rng - b_rng), 32'd1);
    check("rng_nofv",  32'(n_fv - b_fv),   32'd0);
    check("rng_total", 32'(total_sec),     32'd0);
    check("rng_su",    32'(sec_unit),      32'd0);
    check("rng_st",    32'(sec_ten),       32'd0);
    // dp low on idx0: dp_err, yet the frame still commits.
    snap();
    send_digit(4'b1110, 4'd2, 1'b0, DW);
    send_digit(4'b1101, 4'd0, 1'b1, DW);
    send_digit(4'b1011, 4'd0, 1'b0, DW);
    send_digit(4'b0111, 4'd0, 1'b1, DW);
    send_digit(4'b1111, 4'd0, 1'b1, 4);
    check("dp_pulse",  32'(n_dp - b_dp),      32'd1);
    check("dp_fv",     32'(n_fv - b_fv),      32'd1);
    check("dp_total",  32'(total_sec),        32'd2);
    check("dp_status", 32'(err_status[3:0]),  32'd12);

    // Reset after the idx1 capture. The half frame is lost.
    send_digit(4'b1110, 4'd5, 1'b1, DW);
    send_digit(4'b1101, 4'd5, 1'b1, DW);
    MUX_RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge MUX_CLK);
      check_zero("mid_rst");
    end
    MUX_RST = 1'b0;
    snap();
    send_digit(4'b1011, 4'd9, 1'b0, DW);
    send_digit(4'b0111, 4'd1, 1'b1, DW);
    send_digit(4'b1111, 4'd0, 1'b1, 4);
    check("rst_nofv",  32'(n_fv - b_fv), 32'd0);
    check("rst_total", 32'(total_sec),   32'd0);
    check("rst_mt",    32'(min_ten),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
